// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: time-multiplexed scan controller for a common-anode
// seven-segment display. Scans NUM_DIGITS digits with a blanking gap
// between digits and takes new display data over a valid/ready handshake,
// committing it only at frame boundaries (or while idle) so that a frame
// never mixes old and new data.
// Optional build macro SSD_SCAN_LZB_EN enables leading-zero blanking.
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    ssd_scan_port_clk,
    input  logic                    ssd_scan_port_rst_n,
    input  logic                    ssd_scan_port_en,
    input  logic                    ssd_scan_port_load_valid,
    output logic                    ssd_scan_port_load_ready,
    input  logic [4*NUM_DIGITS-1:0] ssd_scan_port_load_value,
    input  logic [NUM_DIGITS-1:0]   ssd_scan_port_load_dp,
    output logic [3:0]              ssd_scan_port_digit,
    output logic                    ssd_scan_port_dp,
    output logic [7:0]              ssd_scan_port_an,
    output logic                    ssd_scan_port_frame_done
);

    localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNTW = $clog2(CMAX + 1);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NUM_DIGITS - 1);
    localparam logic [CNTW-1:0] SHOW_LAST = CNTW'(REFRESH_DIV - 1);
    localparam logic [CNTW-1:0] BLNK_LAST = CNTW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;

    state_e                  state_q;
    logic [IDXW-1:0]         idx_q;
    logic [CNTW-1:0]         cnt_q;
    logic [4*NUM_DIGITS-1:0] act_val_q, shd_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, shd_dp_q, act_dp_d;
    logic                    pend_q, ready_q;
    logic [7:0]              an_q;
    logic [3:0]              digit_q;
    logic                    dp_q, fdone_q;

    logic                    show_end, frame_end, commit, accept;
    logic [IDXW-1:0]         idx_nxt;
    logic [7:0]              an_show;
    logic                    lit;

    assign ssd_scan_port_load_ready = ready_q;
    assign ssd_scan_port_an         = an_q;
    assign ssd_scan_port_digit      = digit_q;
    assign ssd_scan_port_dp         = dp_q;
    assign ssd_scan_port_frame_done = fdone_q;

    // Frame boundary and commit/accept decisions for the coming edge
    always_comb begin
        show_end  = (state_q == SHOW) && (cnt_q == SHOW_LAST);
        frame_end = ssd_scan_port_en && show_end && (idx_q == LAST_IDX);
        commit    = pend_q && (frame_end || (state_q == IDLE));
        accept    = ssd_scan_port_load_valid && ready_q;
        idx_nxt   = (idx_q == LAST_IDX) ? '0 : idx_q + IDXW'(1);
        // Digit/DP preloaded at BLANK entry must already see a commit made
        // on the same edge, so new data starts exactly at digit 0.
        act_val_d = commit ? shd_val_q : act_val_q;
        act_dp_d  = commit ? shd_dp_q  : act_dp_q;
    end

`ifdef SSD_SCAN_LZB_EN
    logic [IDXW-1:0] msnz;

    // Index of the most-significant nonzero nibble (0 when value is 0)
    always_comb begin
        msnz = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (act_val_q[4*i +: 4] != 4'h0) msnz = IDXW'(i);
    end
`endif

    // Anode pattern for the digit about to enter SHOW
    always_comb begin
        an_show = 8'hFF;
        lit     = 1'b1;
`ifdef SSD_SCAN_LZB_EN
        lit     = !((idx_q > msnz) && !act_dp_q[idx_q]);
`endif
        if (lit) an_show[idx_q] = 1'b0;
    end

    // Scan FSM with registered anode/digit/dp/frame_done outputs
    always_ff @(posedge ssd_scan_port_clk or negedge ssd_scan_port_rst_n) begin
        if (!ssd_scan_port_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            an_q    <= 8'hFF;
            digit_q <= 4'h0;
            dp_q    <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            fdone_q <= 1'b0;
            if (!ssd_scan_port_en) begin
                state_q <= IDLE;
                idx_q   <= '0;
                cnt_q   <= '0;
                an_q    <= 8'hFF;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= BLANK;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        an_q    <= 8'hFF;
                        digit_q <= act_val_d[3:0];
                        dp_q    <= act_dp_d[0];
                    end
                    BLANK: begin
                        if (cnt_q == BLNK_LAST) begin
                            state_q <= SHOW;
                            cnt_q   <= '0;
                            an_q    <= an_show;
                        end else begin
                            cnt_q   <= cnt_q + CNTW'(1);
                        end
                    end
                    SHOW: begin
                        if (show_end) begin
                            state_q <= BLANK;
                            cnt_q   <= '0;
                            idx_q   <= idx_nxt;
                            an_q    <= 8'hFF;
                            digit_q <= act_val_d[{idx_nxt, 2'b00} +: 4];
                            dp_q    <= act_dp_d[idx_nxt];
                            fdone_q <= (idx_q == LAST_IDX);
                        end else begin
                            cnt_q   <= cnt_q + CNTW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Load handshake: single shadow slot, committed at frame end or while idle
    always_ff @(posedge ssd_scan_port_clk or negedge ssd_scan_port_rst_n) begin
        if (!ssd_scan_port_rst_n) begin
            act_val_q <= '0;
            act_dp_q  <= '0;
            shd_val_q <= '0;
            shd_dp_q  <= '0;
            pend_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            act_val_q <= act_val_d;
            act_dp_q  <= act_dp_d;
            if (commit) begin
                pend_q  <= 1'b0;
                ready_q <= 1'b1;
            end else if (accept) begin
                shd_val_q <= ssd_scan_port_load_value;
                shd_dp_q  <= ssd_scan_port_load_dp;
                pend_q    <= 1'b1;
                ready_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl (NUM_DIGITS=8, REFRESH_DIV=4, BLANK_CYCLES=2).
// Each digit slot is 6 cycles (2 blank + 4 show); a frame is 48 cycles.
module tb_ssd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, en, lv, ready, dp, fd;
    logic [31:0] val;
    logic [7:0]  ldp, an;
    logic [3:0]  digit;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef SSD_SCAN_LZB_EN
    localparam int LIT42 = 1;
    localparam int LIT0  = 0;
`else
    localparam int LIT42 = 7;
    localparam int LIT0  = 7;
`endif

    typedef struct {
        logic [7:0] an;
        logic [3:0] digit;
        logic       dp;
    } slot_vec_t;

    slot_vec_t tv [8];

    ssd_scan_ctrl #(.NUM_DIGITS(8), .REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
        .ssd_scan_port_clk        (clk),
        .ssd_scan_port_rst_n      (rst_n),
        .ssd_scan_port_en         (en),
        .ssd_scan_port_load_valid (lv),
        .ssd_scan_port_load_ready (ready),
        .ssd_scan_port_load_value (val),
        .ssd_scan_port_load_dp    (ldp),
        .ssd_scan_port_digit      (digit),
        .ssd_scan_port_dp         (dp),
        .ssd_scan_port_an         (an),
        .ssd_scan_port_frame_done (fd)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Checks frame positions f0..47; slots above lit_max are expected dark
    task automatic check_frame(input int f0, input logic [31:0] v, input logic [7:0] m,
                               input int lit_max, input logic fd0);
        for (int f = f0; f < 48; f++) begin
            int s, p;
            logic [7:0] ea;
            s  = f / 6;
            p  = f % 6;
            ea = 8'hFF;
            if (p >= 2 && s <= lit_max) ea[s] = 1'b0;
            chk("frame_an", 32'(an), 32'(ea));
            chk("frame_digit", 32'(digit), 32'(v[4*s +: 4]));
            chk("frame_dp", 32'(dp), 32'(m[s]));
            chk("frame_fd", 32'(fd), (f == 0) ? 32'(fd0) : 32'd0);
            tick();
        end
    endtask

    initial begin
        int cnt;
        tv[0] = '{8'hFE, 4'hD, 1'b1};
        tv[1] = '{8'hFD, 4'hC, 1'b0};
        tv[2] = '{8'hFB, 4'hB, 1'b0};
        tv[3] = '{8'hF7, 4'hA, 1'b0};
        tv[4] = '{8'hEF, 4'h4, 1'b0};
        tv[5] = '{8'hDF, 4'h3, 1'b0};
        tv[6] = '{8'hBF, 4'h2, 1'b0};
        tv[7] = '{8'h7F, 4'h1, 1'b0};

        rst_n = 1'b0; en = 1'b0; lv = 1'b0; val = '0; ldp = '0;
        repeat (3) tick();
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_fd", 32'(fd), 32'd0);
        chk("rst_digit", 32'(digit), 32'd0);
        chk("rst_dp", 32'(dp), 32'd0);
        rst_n = 1'b1;
        tick();

        // First enable: 2 blank cycles, then digit 0 lit with value 0
        en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("pwr_an", 32'(an), (k <= 2) ? 32'hFF : 32'hFE);
            chk("pwr_digit", 32'(digit), 32'd0);
            chk("pwr_fd", 32'(fd), 32'd0);
        end
        en = 1'b0;
        tick();
        chk("dis_an", 32'(an), 32'hFF);

        // Load while idle: commits on the next edge
        lv = 1'b1; val = 32'h1234ABCD; ldp = 8'h01;
        tick();
        chk("idle_ld_ready0", 32'(ready), 32'd0);
        lv = 1'b0;
        tick();
        chk("idle_ld_ready1", 32'(ready), 32'd1);

        // Full frame against the hand-written slot table
        en = 1'b1;
        tick();
        for (int f = 0; f < 48; f++) begin
            int s, p;
            s = f / 6;
            p = f % 6;
            chk("tbl_an", 32'(an), (p < 2) ? 32'hFF : 32'(tv[s].an));
            chk("tbl_digit", 32'(digit), 32'(tv[s].digit));
            chk("tbl_dp", 32'(dp), 32'(tv[s].dp));
            chk("tbl_fd", 32'(fd), 32'd0);
            tick();
        end
        chk("frame1_done", 32'(fd), 32'd1);

        // Frame period measured between frame_done pulses
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!fd && cnt < 100);
        chk("frame_period", 32'(cnt), 32'd48);

        // Mid-frame load at index 3; rest of frame keeps old data
        repeat (18) tick();
        chk("mid_ready_pre", 32'(ready), 32'd1);
        lv = 1'b1; val = 32'hFFFFFFFF; ldp = 8'h00;
        tick();
        chk("mid_ready0", 32'(ready), 32'd0);
        // second offer held while not ready must not be taken yet
        val = 32'h55555555; ldp = 8'hFF;
        for (int f = 19; f < 48; f++) begin
            chk("mid_old_digit", 32'(digit), 32'(tv[f / 6].digit));
            chk("mid_ready_low", 32'(ready), 32'd0);
            tick();
        end
        chk("commit_fd", 32'(fd), 32'd1);
        chk("commit_ready", 32'(ready), 32'd1);
        chk("commit_digit0", 32'(digit), 32'hF);
        tick();
        chk("second_accept", 32'(ready), 32'd0);
        lv = 1'b0;
        check_frame(1, 32'hFFFFFFFF, 8'h00, 7, 1'b0);
        check_frame(0, 32'h55555555, 8'hFF, 7, 1'b1);
        chk("after_second_ready", 32'(ready), 32'd1);

        // Drop enable at index 5, then restart from index 0
        repeat (32) tick();
        chk("idx5_an", 32'(an), 32'hDF);
        en = 1'b0;
        tick();
        chk("drop_an", 32'(an), 32'hFF);
        chk("drop_fd", 32'(fd), 32'd0);
        repeat (2) tick();
        chk("drop_an_hold", 32'(an), 32'hFF);
        en = 1'b1;
        tick();
        chk("re_an_b0", 32'(an), 32'hFF);
        chk("re_digit", 32'(digit), 32'h5);
        chk("re_dp", 32'(dp), 32'd1);
        tick();
        chk("re_an_b1", 32'(an), 32'hFF);
        tick();
        chk("re_an_show", 32'(an), 32'hFE);

        // Leading-zero cases: 0x42 and 0
        en = 1'b0;
        tick();
        lv = 1'b1; val = 32'h00000042; ldp = 8'h00;
        tick();
        lv = 1'b0;
        tick();
        chk("lz42_ready", 32'(ready), 32'd1);
        en = 1'b1;
        tick();
        check_frame(0, 32'h00000042, 8'h00, LIT42, 1'b0);
        chk("lz42_fd", 32'(fd), 32'd1);

        en = 1'b0;
        tick();
        lv = 1'b1; val = 32'h00000000; ldp = 8'h00;
        tick();
        lv = 1'b0;
        tick();
        en = 1'b1;
        tick();
        check_frame(0, 32'h00000000, 8'h00, LIT0, 1'b0);
        chk("lz0_fd", 32'(fd), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display.
- Holds a 32-bit hex value plus per-digit decimal-point mask and sequences one digit at a time onto the shared segment encoder.
  - Drives the nibble and DP input of the existing encoder.
  - Owns the active-low anode bus.
- Inserts blanking between digits to suppress ghosting.
- Accepts new display data via valid/ready and commits it only at frame boundaries, so no tearing.

Parameters:
- NUM_DIGITS, 8: digits scanned. Range 2..8. Data width is 4*NUM_DIGITS.
- REFRESH_DIV, 100000: clock cycles each digit is lit in SHOW (1 kHz/digit at 100 MHz). Must be ≥ 2.
- BLANK_CYCLES, 16: cycles all anodes are off between digits. Must be ≥ 1.

Ports:
- ssd_scan_port_clk  input  1  system clock, rising edge.
- ssd_scan_port_rst_n  input  1  asynchronous active-low reset.
- ssd_scan_port_en  input  1  scan enable; low forces display dark.
- ssd_scan_port_load_valid  input  1  new value/DP mask offered.
- ssd_scan_port_load_ready  output  1  controller can accept a load.
- ssd_scan_port_load_value  input  4*NUM_DIGITS  hex value; digit 0 = bits [3:0].
- ssd_scan_port_load_dp  input  NUM_DIGITS  DP mask; 1 = point lit.
- ssd_scan_port_digit  output  4  nibble to segment encoder.
- ssd_scan_port_dp  output  1  DP to encoder, active-high (encoder inverts).
- ssd_scan_port_an  output  8  anodes, active-low. Bits ≥ NUM_DIGITS are tied 1.
- ssd_scan_port_frame_done  output  1  one-cycle pulse after the last digit's SHOW.

Behaviour:
- Reset (async assert, sync-released use):
  - state=IDLE, digit index=0, phase counter=0.
  - active value=0, active DP mask=0, pending flag=0.
  - an=8'hFF, digit=4'h0, dp=0, load_ready=1, frame_done=0.
- All outputs registered. an/digit/dp change on the same edge as the state change.
- States:
  - IDLE:
    - an=all 1s.
    - If en=1: go to BLANK with index=0, counter=0.
  - BLANK:
    - an=all 1s; digit/dp already show index's values.
    - After BLANK_CYCLES cycles: go to SHOW.
  - SHOW:
    - an[index]=0, all other anodes 1.
    - digit = active value nibble[index]; dp = active DP[index].
    - After REFRESH_DIV cycles: if index==NUM_DIGITS-1, set index=0, pulse frame_done, and commit pending. Else index+1. Then go to BLANK.
  - Any state: en=0 → IDLE next cycle.
    - an=all 1s, index=0.
    - Pending data is kept; frame_done is not pulsed.
- Frame period: NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.
- Load handshake:
  - Transfer occurs when load_valid & load_ready on a rising edge. Value and DP go to a shadow register; pending=1; load_ready=0 from the next cycle.
  - Commit happens on the frame_done edge, or on any edge while state is IDLE. Commit copies shadow to active, pending=0, load_ready=1 the next cycle.
  - Committed data first appears at digit 0 of the next frame.
  - Only one pending load at a time. valid while ready=0 is ignored; the source holds it.
- Commit and transfer never coincide, because ready=0 whenever pending=1.
- Reset mid-scan: immediate dark display (an=FF). Shadow and pending are discarded.

Optional Feature:
- Macro: SSD_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - During SHOW, a digit's anode is held 1 when its index > the most-significant nonzero nibble of the active value and its DP bit is 0.
  - Digit 0 is always lit; value 0 shows a single "0".
  - Timing and frame period are unchanged. Blanked digits still consume their slots.
- Undefined: all NUM_DIGITS digits are always lit in SHOW.

Test Plan (NUM_DIGITS=8, REFRESH_DIV=4, BLANK_CYCLES=2):
- Reset → an=FF, load_ready=1, frame_done=0. Raise en → 2 cycles an=FF, then 4 cycles an=FE with digit=0.
- Load 32'h1234ABCD, dp=8'h01, in IDLE, then en=1 → digit sequence D,C,B,A,4,3,2,1 on an FE,FD,FB,...,7F. dp=1 only at index 0. frame_done pulses once every 48 cycles.
- Mid-frame at index 3: load 32'hFFFFFFFF → load_ready=0 until frame_done. Remaining digits of the frame still show old data. The next frame shows F on all digits.
- Second valid while ready=0 → ignored. After commit the first load's data is displayed; the second is accepted only when ready=1.
- en dropped at index 5 → an=FF next cycle. Re-enable → scan restarts at index 0 after BLANK.
- SSD_SCAN_LZB_EN defined, value 32'h00000042, dp=0 → only an FE/FD ever go low; value 0 → only FE lit with digit=0.
